condicionador_botoes: RTL and testbench



---
 rtl/geogenius_pkg.sv | 44 ++++
 rtl/condicionador_botoes_sincronizador_2ff.sv | 35 +++
 rtl/condicionador_botoes.sv | 181 ++++++++++++++++++
 tb/tb_condicionador_botoes.sv | 197 +++++++++++++++++++
 4 files changed

// File: rtl/geogenius_pkg.sv
// Shared definitions for the game input path: FSM state encoding, button
// count, default debounce length and small bit-vector helpers used by the
// button conditioner.
package geogenius_pkg;

    // Fixed by the datapath's wide-OR edge detector; not a scalable parameter.
    localparam int N_BOTOES               = 8;
    // 20 ms at the 1 kHz game clock.
    localparam int DEBOUNCE_CICLOS_PADRAO = 20;

    typedef enum logic [1:0] {
        LIVRE       = 2'd0,
        FILTRANDO   = 2'd1,
        PRESSIONADO = 2'd2,
        SOLTANDO    = 2'd3
    } estado_t;

    // Index of the lowest set bit (0 when the vector is empty).
    function automatic logic [2:0] indice_menor(input logic [N_BOTOES-1:0] v);
        logic [2:0] idx;
        idx = '0;
        for (int i = N_BOTOES - 1; i >= 0; i--) begin
            if (v[i]) begin
                idx = 3'(i);
            end
        end
        return idx;
    endfunction

    // Keeps only the lowest set bit, giving a one-hot (or empty) vector.
    function automatic logic [N_BOTOES-1:0] isola_menor(input logic [N_BOTOES-1:0] v);
        logic [N_BOTOES-1:0] neg;
        neg = ~v + {{(N_BOTOES-1){1'b0}}, 1'b1};
        return v & neg;
    endfunction

    // True when exactly one bit is set.
    function automatic logic um_bit(input logic [N_BOTOES-1:0] v);
        logic [N_BOTOES-1:0] menos_um;
        menos_um = v - {{(N_BOTOES-1){1'b0}}, 1'b1};
        return (v != '0) && ((v & menos_um) == '0);
    endfunction

endpackage

// File: rtl/condicionador_botoes_sincronizador_2ff.sv
// Two-flop synchroniser for a bus of independent asynchronous bits.
// Each bit gets its own flop pair; the reset value is a parameter so that
// active-low inputs can idle at "released" straight out of reset.
module sincronizador_2ff #(
    parameter int           W           = 8,
    parameter logic [W-1:0] VALOR_RESET = '1
) (
    input  logic         clock,
    input  logic         reset,
    input  logic [W-1:0] d,
    output logic [W-1:0] q
);

    genvar gi;
    generate
        for (gi = 0; gi < W; gi++) begin : g_bit
            logic estagio1_q;
            logic estagio2_q;

            // Two-stage capture of one raw bit into the clock domain.
            always_ff @(posedge clock or posedge reset) begin
                if (reset) begin
                    estagio1_q <= VALOR_RESET[gi];
                    estagio2_q <= VALOR_RESET[gi];
                end else begin
                    estagio1_q <= d[gi];
                    estagio2_q <= estagio1_q;
                end
            end

            assign q[gi] = estagio2_q;
        end
    endgenerate

endmodule

// File: rtl/condicionador_botoes.sv
// Button conditioner: synchronises the eight active-low game buttons,
// debounces press and release, and admits a single button at a time so the
// datapath sees exactly one press per physical press.
// Optional feature: define REJEITA_MULTIPLO_EN to reject simultaneous
// multi-button presses (pulse erro_multiplo, output stays released) instead
// of accepting the lowest-numbered button.
module condicionador_botoes
    import geogenius_pkg::*;
#(
    parameter int DEBOUNCE_CICLOS = DEBOUNCE_CICLOS_PADRAO,
    // Must satisfy 2**CNT_W >= DEBOUNCE_CICLOS.
    parameter int CNT_W           = 5
) (
    input  logic                clock,
    input  logic                reset,
    input  logic [N_BOTOES-1:0] botoes_brutos,
    input  logic                habilita,
    output logic [N_BOTOES-1:0] botoes,
    output logic                botao_valido,
    output logic [2:0]          botao_codigo,
    output logic                erro_multiplo
);

    localparam logic [CNT_W-1:0] CNT_FIM = CNT_W'(DEBOUNCE_CICLOS - 1);

    logic [N_BOTOES-1:0] sync_q;
    logic [N_BOTOES-1:0] p;

    estado_t             estado_q, estado_d;
    logic [N_BOTOES-1:0] candidato_q, candidato_d;
    logic [N_BOTOES-1:0] seguro_q, seguro_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic [N_BOTOES-1:0] botoes_q, botoes_d;
    logic                valido_q, valido_d;
    logic [2:0]          codigo_q, codigo_d;
    logic                aceita;
`ifdef REJEITA_MULTIPLO_EN
    logic                erro_q, erro_d;
    logic                rejeita;
`endif

    sincronizador_2ff #(
        .W           (N_BOTOES),
        .VALOR_RESET ({N_BOTOES{1'b1}})
    ) u_sinc (
        .clock (clock),
        .reset (reset),
        .d     (botoes_brutos),
        .q     (sync_q)
    );

    // Internal polarity: 1 = pressed.
    assign p = ~sync_q;

    // State and registered-output update.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            estado_q    <= LIVRE;
            candidato_q <= '0;
            seguro_q    <= '0;
            cnt_q       <= '0;
            botoes_q    <= '1;
            valido_q    <= 1'b0;
            codigo_q    <= '0;
`ifdef REJEITA_MULTIPLO_EN
            erro_q      <= 1'b0;
`endif
        end else begin
            estado_q    <= estado_d;
            candidato_q <= candidato_d;
            seguro_q    <= seguro_d;
            cnt_q       <= cnt_d;
            botoes_q    <= botoes_d;
            valido_q    <= valido_d;
            codigo_q    <= codigo_d;
`ifdef REJEITA_MULTIPLO_EN
            erro_q      <= erro_d;
`endif
        end
    end

    // Next-state logic: debounce filter, single-button admission, release tracking.
    always_comb begin
        estado_d    = estado_q;
        candidato_d = candidato_q;
        seguro_d    = seguro_q;
        cnt_d       = cnt_q;
        aceita      = 1'b0;
`ifdef REJEITA_MULTIPLO_EN
        rejeita     = 1'b0;
`endif
        case (estado_q)
            LIVRE: begin
                if (habilita && (p != '0)) begin
                    candidato_d = p;
                    cnt_d       = '0;
                    estado_d    = FILTRANDO;
                end
            end
            FILTRANDO: begin
                // Any change in the pressed set (or loss of permission) restarts filtering.
                if ((p != candidato_q) || !habilita) begin
                    estado_d = LIVRE;
                end else if (cnt_q == CNT_FIM) begin
`ifdef REJEITA_MULTIPLO_EN
                    if (um_bit(candidato_q)) begin
                        seguro_d = candidato_q;
                        aceita   = 1'b1;
                        estado_d = PRESSIONADO;
                    end else begin
                        // Output stays released until every button is up and stable.
                        seguro_d = '0;
                        rejeita  = 1'b1;
                        cnt_d    = '0;
                        estado_d = SOLTANDO;
                    end
`else
                    // Lowest set bit wins; for a single press this is the press itself.
                    seguro_d = isola_menor(candidato_q);
                    aceita   = 1'b1;
                    estado_d = PRESSIONADO;
`endif
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            PRESSIONADO: begin
                if ((p & seguro_q) == '0) begin
                    cnt_d    = '0;
                    estado_d = SOLTANDO;
                end
            end
            SOLTANDO: begin
                if (((p & seguro_q) != '0) && (seguro_q != '0)) begin
                    // Bounce on the held button: back to pressed without a new pulse.
                    estado_d = PRESSIONADO;
                end else if (p == '0) begin
                    if (cnt_q == CNT_FIM) begin
                        seguro_d = '0;
                        cnt_d    = '0;
                        estado_d = LIVRE;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end else begin
                    // Another button is down: release needs all buttons up (no roll-over).
                    cnt_d = '0;
                end
            end
            default: begin
                estado_d = LIVRE;
            end
        endcase
    end

    // Output logic, computed from next-state values so outputs change on the accepting edge.
    always_comb begin
        botoes_d = '1;
        if ((estado_d == PRESSIONADO) || (estado_d == SOLTANDO)) begin
            botoes_d = ~seguro_d;
        end
        valido_d = aceita;
        codigo_d = codigo_q;
        if (aceita) begin
            codigo_d = indice_menor(candidato_q);
        end
`ifdef REJEITA_MULTIPLO_EN
        erro_d = rejeita;
`endif
    end

    assign botoes       = botoes_q;
    assign botao_valido = valido_q;
    assign botao_codigo = codigo_q;
`ifdef REJEITA_MULTIPLO_EN
    assign erro_multiplo = erro_q;
`else
    assign erro_multiplo = 1'b0;
`endif

endmodule

// File: tb/tb_condicionador_botoes.sv
// Directed bench for condicionador_botoes: press/release latency, bounce
// rejection, multi-press handling (both builds), roll-over blocking,
// habilita gating and asynchronous reset.
module tb_condicionador_botoes;

    logic       clock;
    logic       reset;
    logic [7:0] botoes_brutos;
    logic       habilita;
    logic [7:0] botoes;
    logic       botao_valido;
    logic [2:0] botao_codigo;
    logic       erro_multiplo;

    int n_comparados  = 0;
    int n_divergentes = 0;
    int n_pulsos      = 0;
    int n_erros       = 0;
    int base_pulsos;
    int base_erros;

    condicionador_botoes dut (
        .clock         (clock),
        .reset         (reset),
        .botoes_brutos (botoes_brutos),
        .habilita      (habilita),
        .botoes        (botoes),
        .botao_valido  (botao_valido),
        .botao_codigo  (botao_codigo),
        .erro_multiplo (erro_multiplo)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Count pulses as seen by the downstream logic on each rising edge.
    always @(posedge clock) begin
        if (botao_valido)  n_pulsos++;
        if (erro_multiplo) n_erros++;
    end

    task automatic confere(input string tag, input logic [31:0] obs, input logic [31:0] esp);
        n_comparados++;
        if (obs !== esp) begin
            n_divergentes++;
            $display("FAIL %s: obtido=%0h esperado=%0h", tag, obs, esp);
        end else begin
            $display("ok   %s: %0h", tag, obs);
        end
    endtask

    // Advance n rising edges, then settle 1 time unit past the last one.
    task automatic avanca(input int n);
        repeat (n) @(posedge clock);
        #1;
    endtask

    initial begin
        reset         = 1'b1;
        habilita      = 1'b1;
        botoes_brutos = 8'hFF;
        avanca(3);
        confere("reset_botoes", 32'(botoes), 32'hFF);
        confere("reset_valido", 32'(botao_valido), 32'h0);
        confere("reset_codigo", 32'(botao_codigo), 32'h0);
        confere("reset_erro",   32'(erro_multiplo), 32'h0);
        reset = 1'b0;
        avanca(3);

        // Clean press of bit 3, held 40 cycles.
        base_pulsos   = n_pulsos;
        botoes_brutos = 8'hF7;
        avanca(22);
        confere("p3_antes_borda22", 32'(botoes), 32'hFF);
        confere("p3_valido_antes", 32'(botao_valido), 32'h0);
        avanca(1);
        confere("p3_botoes", 32'(botoes), 32'hF7);
        confere("p3_valido", 32'(botao_valido), 32'h1);
        confere("p3_codigo", 32'(botao_codigo), 32'h3);
        avanca(1);
        confere("p3_valido_1ciclo", 32'(botao_valido), 32'h0);
        avanca(16);
        botoes_brutos = 8'hFF;
        avanca(22);
        confere("p3_solta_antes", 32'(botoes), 32'hF7);
        avanca(1);
        confere("p3_solta_botoes", 32'(botoes), 32'hFF);
        confere("p3_n_pulsos", 32'(n_pulsos - base_pulsos), 32'h1);
        avanca(3);

        // Bounce on bit 0: three 5-cycle low pulses, then stable low.
        base_pulsos = n_pulsos;
        for (int k = 0; k < 3; k++) begin
            botoes_brutos = 8'hFE;
            avanca(5);
            botoes_brutos = 8'hFF;
            avanca(5);
        end
        confere("b0_durante_ressalto", 32'(botoes), 32'hFF);
        botoes_brutos = 8'hFE;
        avanca(22);
        confere("b0_antes", 32'(botoes), 32'hFF);
        confere("b0_sem_pulso_antes", 32'(n_pulsos - base_pulsos), 32'h0);
        avanca(1);
        confere("b0_botoes", 32'(botoes), 32'hFE);
        confere("b0_valido", 32'(botao_valido), 32'h1);
        confere("b0_codigo", 32'(botao_codigo), 32'h0);
        avanca(5);
        botoes_brutos = 8'hFF;
        avanca(25);
        confere("b0_solto", 32'(botoes), 32'hFF);
        confere("b0_n_pulsos", 32'(n_pulsos - base_pulsos), 32'h1);

        // Bits 1 and 5 pressed together.
        base_pulsos   = n_pulsos;
        base_erros    = n_erros;
        botoes_brutos = 8'hDD;
        avanca(23);
`ifdef REJEITA_MULTIPLO_EN
        confere("multi_botoes", 32'(botoes), 32'hFF);
        confere("multi_erro", 32'(erro_multiplo), 32'h1);
        confere("multi_valido", 32'(botao_valido), 32'h0);
`else
        confere("multi_botoes", 32'(botoes), 32'hFD);
        confere("multi_valido", 32'(botao_valido), 32'h1);
        confere("multi_codigo", 32'(botao_codigo), 32'h1);
`endif
        avanca(1);
        confere("multi_erro_depois", 32'(erro_multiplo), 32'h0);
        avanca(10);
        botoes_brutos = 8'hFF;
        avanca(25);
        confere("multi_solto", 32'(botoes), 32'hFF);
`ifdef REJEITA_MULTIPLO_EN
        confere("multi_n_erros", 32'(n_erros - base_erros), 32'h1);
        confere("multi_n_pulsos", 32'(n_pulsos - base_pulsos), 32'h0);
`else
        confere("multi_n_erros", 32'(n_erros - base_erros), 32'h0);
        confere("multi_n_pulsos", 32'(n_pulsos - base_pulsos), 32'h1);
`endif

        // Roll-over: bit 2 held, bit 6 pressed, bit 2 released.
        base_pulsos   = n_pulsos;
        botoes_brutos = 8'hFB;
        avanca(23);
        confere("ro_botoes", 32'(botoes), 32'hFB);
        confere("ro_codigo", 32'(botao_codigo), 32'h2);
        botoes_brutos = 8'hBB;
        avanca(5);
        confere("ro_ambos", 32'(botoes), 32'hFB);
        botoes_brutos = 8'hBF;
        avanca(30);
        confere("ro_so_b6", 32'(botoes), 32'hFB);
        confere("ro_n_pulsos", 32'(n_pulsos - base_pulsos), 32'h1);
        botoes_brutos = 8'hFF;
        avanca(21);
        confere("ro_solta_antes", 32'(botoes), 32'hFB);
        avanca(1);
        confere("ro_solta", 32'(botoes), 32'hFF);
        avanca(3);

        // habilita low during a press of bit 4, then raised while still held.
        base_pulsos   = n_pulsos;
        habilita      = 1'b0;
        botoes_brutos = 8'hEF;
        avanca(40);
        confere("hab0_botoes", 32'(botoes), 32'hFF);
        confere("hab0_n_pulsos", 32'(n_pulsos - base_pulsos), 32'h0);
        habilita = 1'b1;
        avanca(20);
        confere("hab1_antes", 32'(botoes), 32'hFF);
        avanca(1);
        confere("hab1_botoes", 32'(botoes), 32'hEF);
        confere("hab1_valido", 32'(botao_valido), 32'h1);
        confere("hab1_codigo", 32'(botao_codigo), 32'h4);
        avanca(5);

        // Asynchronous reset while pressed.
        base_pulsos = n_pulsos;
        #2;
        reset = 1'b1;
        #1;
        confere("rst_pressionado_botoes", 32'(botoes), 32'hFF);
        confere("rst_pressionado_codigo", 32'(botao_codigo), 32'h0);
        confere("rst_pressionado_valido", 32'(botao_valido), 32'h0);
        botoes_brutos = 8'hFF;
        avanca(3);
        reset = 1'b0;
        avanca(30);
        confere("rst_depois_botoes", 32'(botoes), 32'hFF);
        confere("rst_n_pulsos", 32'(n_pulsos - base_pulsos), 32'h0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_comparados, n_divergentes);
        $finish;
    end

endmodule
